// File: rtl/mac_psum_engine_pkg.sv
// Shared widths, FSM encoding and product sign-extension
// for the PE partial-sum engine.
package mac_psum_engine_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PSUM_W = 24;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  function automatic logic signed [DEF_PSUM_W-1:0]
    sext_prod(input logic signed [2*DEF_DATA_W-1:0] p);
    return DEF_PSUM_W'(p);
  endfunction

endpackage

// File: rtl/mac_psum_engine_if.sv
// Seed / operand / result handshake bundle of the
// partial-sum engine.
interface mac_psum_engine_if #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 24,
  parameter int LEN_W  = 8
);
  logic [LEN_W-1:0]  cfg_len;
  logic              psum_in_valid;
  logic              psum_in_ready;
  logic [PSUM_W-1:0] psum_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ifmap;
  logic [DATA_W-1:0] filter;
  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_psum;
  logic              busy;

  modport master (
    output cfg_len, psum_in_valid, psum_in,
    output in_valid, ifmap, filter, out_ready,
    input  psum_in_ready, in_ready,
    input  out_valid, out_psum, busy
  );

  modport slave (
    input  cfg_len, psum_in_valid, psum_in,
    input  in_valid, ifmap, filter, out_ready,
    output psum_in_ready, in_ready,
    output out_valid, out_psum, busy
  );
endinterface

// File: rtl/mac_psum_engine_mac.sv
// Combinational int8 x int8 + psum24 MAC; wraps modulo
// 2^PSUM_W with no saturation.
module mac_psum_engine_mac
  import mac_psum_engine_pkg::*;
(
  input  logic signed [DEF_DATA_W-1:0] ifmap,
  input  logic signed [DEF_DATA_W-1:0] filter,
  input  logic signed [DEF_PSUM_W-1:0] psum,
  output logic signed [DEF_PSUM_W-1:0] updated_psum
);
  logic signed [2*DEF_DATA_W-1:0] prod;

  assign prod         = ifmap * filter;
  assign updated_psum = psum + sext_prod(prod);
endmodule

// File: rtl/mac_psum_engine.sv
// Seed -> N-product accumulate -> emit FSM wrapped
// around the MAC datapath.
module mac_psum_engine
  import mac_psum_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic              clk,
  input logic              rst,
  mac_psum_engine_if.slave bus
);
  state_t state, nxt;

  logic [PSUM_W-1:0] acc;
  logic [PSUM_W-1:0] acc_nxt;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic seed_fire;
  logic pair_fire;
  logic out_fire;
  logic last;

  assign op_a = bus.ifmap;
  assign op_b = bus.filter;

  mac_psum_engine_mac u_mac (
    .ifmap        (op_a),
    .filter       (op_b),
    .psum         (acc),
    .updated_psum (acc_nxt)
  );

  assign seed_fire = bus.psum_in_valid
                   & bus.psum_in_ready;
  assign pair_fire = bus.in_valid & bus.in_ready;
  assign out_fire  = bus.out_ready & bus.out_valid;
  assign last      = cnt == len_q - LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (seed_fire)
        nxt = (bus.cfg_len == '0) ? S_OUT : S_ACC;
      S_ACC: if (pair_fire && last)
        nxt = S_OUT;
      S_OUT: if (out_fire)
        nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Readies depend on state only, never on valids.
  always_comb begin
    bus.psum_in_ready = 1'b0;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.busy          = 1'b1;
    unique case (1'b1)
      (state == S_IDLE): begin
        bus.psum_in_ready = 1'b1;
        bus.busy          = 1'b0;
      end
      (state == S_ACC): bus.in_ready  = 1'b1;
      (state == S_OUT): bus.out_valid = 1'b1;
      default: bus.busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (seed_fire) begin
      acc   <= bus.psum_in;
      cnt   <= '0;
      len_q <= bus.cfg_len;
    end else if (pair_fire) begin
      acc   <= acc_nxt;
      cnt   <= cnt + LEN_W'(1);
    end
  end

  assign bus.out_psum = acc;
endmodule

// File: tb/tb_mac_psum_engine.sv
// Directed + randomized bench for mac_psum_engine with a
// plain-arithmetic reference model.
module tb_mac_psum_engine;
  logic clk = 1'b0;
  logic rst;

  mac_psum_engine_if #(8, 24, 8) bus ();

  mac_psum_engine #(
    .DATA_W (8),
    .PSUM_W (24),
    .LEN_W  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pa[$];
  int pb[$];
  int seeds[5] = '{32'hFFFFFF, 0, 32'h555555,
                   32'hAAAAAA, 32'h333333};
  int corn[5] = '{-128, -1, 0, 1, 127};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(
    input logic [23:0] seed);
    longint s;
    logic [63:0] r;
    s = longint'(seed);
    foreach (pa[i]) s += longint'(pa[i] * pb[i]);
    r = 64'(s);
    return r[23:0];
  endfunction

  task automatic run_job(input logic [23:0] seed,
                         input int gap,
                         input int bp);
    logic [23:0] ex;
    int n;
    n  = pa.size();
    ex = model(seed);
    check("idle_seed_rdy", 32'(bus.psum_in_ready), 1);
    bus.psum_in_valid = 1'b1;
    bus.psum_in       = seed;
    bus.cfg_len       = 8'(n);
    tick();
    bus.psum_in_valid = 1'b0;
    bus.psum_in       = 24'($urandom);
    bus.cfg_len       = 8'($urandom);
    check("busy_after_seed", 32'(bus.busy), 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.ifmap    = 8'($urandom);
        bus.filter   = 8'($urandom);
        tick();
        check("stall_in_rdy", 32'(bus.in_ready), 1);
        check("stall_no_out", 32'(bus.out_valid), 0);
      end
      check("acc_in_rdy", 32'(bus.in_ready), 1);
      check("acc_seed_rdy", 32'(bus.psum_in_ready), 0);
      bus.in_valid = 1'b1;
      bus.ifmap    = 8'(pa[i]);
      bus.filter   = 8'(pb[i]);
      tick();
      bus.in_valid = 1'b0;
    end
    check("out_valid", 32'(bus.out_valid), 1);
    check("out_psum", 32'(bus.out_psum), 32'(ex));
    check("out_no_in_rdy", 32'(bus.in_ready), 0);
    for (int k = 0; k < bp; k++) begin
      bus.out_ready = 1'b0;
      tick();
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_psum", 32'(bus.out_psum), 32'(ex));
      check("bp_seed_rdy", 32'(bus.psum_in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("retire_valid", 32'(bus.out_valid), 0);
    check("retire_seed_rdy",
          32'(bus.psum_in_ready), 1);
    check("retire_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.cfg_len       = '0;
    bus.psum_in_valid = 1'b0;
    bus.psum_in       = '0;
    bus.in_valid      = 1'b0;
    bus.ifmap         = '0;
    bus.filter        = '0;
    bus.out_ready     = 1'b0;
    tick();
    tick();
    check("rst_seed_rdy", 32'(bus.psum_in_ready), 1);
    check("rst_in_rdy", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_psum", 32'(bus.out_psum), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    tick();

    pa = '{3, -2, -128};
    pb = '{4, 5, -128};
    run_job(24'd100, 0, 3);
    check("const_16486", 32'(model(24'd100)), 16486);

    pa.delete();
    pb.delete();
    run_job(24'hFFFFFF, 0, 0);

    pa = '{127};
    pb = '{127};
    run_job(24'h7FFFFF, 0, 1);
    check("const_wrap", 32'(model(24'h7FFFFF)),
          32'h803F00);

    pa = '{-77, 55};
    pb = '{99, -128};
    run_job(24'h123456, 3, 5);

    bus.psum_in_valid = 1'b1;
    bus.psum_in       = 24'h00ABCD;
    bus.cfg_len       = 8'd4;
    tick();
    bus.psum_in_valid = 1'b0;
    bus.in_valid      = 1'b1;
    bus.ifmap         = 8'd9;
    bus.filter        = 8'd9;
    tick();
    bus.in_valid      = 1'b0;
    rst               = 1'b1;
    tick();
    rst               = 1'b0;
    check("mid_rst_seed_rdy",
          32'(bus.psum_in_ready), 1);
    check("mid_rst_in_rdy", 32'(bus.in_ready), 0);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_acc", 32'(bus.out_psum), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    pa = '{-5, 6, 7, -8};
    pb = '{10, -11, 12, 13};
    run_job(24'h000777, 0, 0);

    foreach (seeds[s])
      foreach (corn[a])
        foreach (corn[b]) begin
          pa = '{corn[a]};
          pb = '{corn[b]};
          run_job(24'(seeds[s]), 0, 0);
        end

    for (int j = 0; j < 1500; j++) begin
      pa = '{int'($urandom_range(0, 255)) - 128};
      pb = '{int'($urandom_range(0, 255)) - 128};
      run_job(24'(seeds[$urandom_range(0, 4)]),
              0, 0);
    end

    for (int j = 0; j < 40; j++) begin
      int n;
      n = $urandom_range(0, 20);
      pa.delete();
      pb.delete();
      for (int i = 0; i < n; i++) begin
        pa.push_back(int'($urandom_range(0, 255)) - 128);
        pb.push_back(int'($urandom_range(0, 255)) - 128);
      end
      run_job(24'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
